// File: rtl/tiny_alu_sequencer.sv
// Sequencer that loads a small program of ALU operations and issues them one per cycle,
// capturing each result two cycles later. Optional SEQ_LOOP_EN adds a loop input that restarts the program at completion.
module tiny_alu_sequencer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_valid,
  input  logic [11:0]                load_data,
  output logic                       load_ready,
  input  logic                       start,
`ifdef SEQ_LOOP_EN
  input  logic                       loop,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 alu_ui,
  output logic [3:0]                 alu_op,
  output logic                       alu_ena,
  input  logic [7:0]                 alu_result,
  output logic                       res_valid,
  output logic [7:0]                 res_data,
  output logic [$clog2(DEPTH)-1:0]   res_index
);

  localparam int unsigned IW      = $clog2(DEPTH);
  localparam logic [3:0]  OP_NOP  = 4'hF;

  typedef logic [IW-1:0] idx_t;
  typedef logic [IW:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_e;

  // Tag that travels alongside an issued entry until its result is captured.
  typedef struct packed {
    logic valid;
    idx_t idx;
    logic last;
  } tag_t;

  state_e      state_q, state_d;
  cnt_t        count_q, count_d;
  idx_t        ptr_q, ptr_d;
  logic [11:0] mem [DEPTH];

  logic        load_ready_q, load_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [7:0]  alu_ui_q, alu_ui_d;
  logic        alu_ena_q, alu_ena_d;
  tag_t        tag0_q, tag0_d, tag1_q, tag2_q;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_data_q, res_data_d;
  idx_t        res_index_q, res_index_d;

  logic        load_fire;
  logic        loop_req;
  logic        empty_done;
  logic        issuing;
  cnt_t        last_idx;
  logic [11:0] entry;

`ifdef SEQ_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    empty_done = 1'b0;

    load_fire  = load_valid & load_ready_q;
    count_d    = count_q + cnt_t'(load_fire);
    last_idx   = count_d - cnt_t'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // A load accepted in the same cycle already counts towards the program.
          if (count_d != '0) begin
            state_d = S_ISSUE;
            ptr_d   = '0;
          end else begin
            empty_done = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if ({1'b0, ptr_q} == last_idx) state_d = S_DRAIN;
        else                           ptr_d   = ptr_q + idx_t'(1);
      end
      S_DRAIN: begin
        if (done_q) begin
          if (loop_req) begin
            state_d = S_ISSUE;
            ptr_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entry 0 may be written in the very cycle it is first issued, so bypass the memory.
    entry   = (load_fire && count_q == '0) ? load_data : mem[ptr_d];
    issuing = (state_d == S_ISSUE);

    alu_op_d     = issuing ? entry[11:8] : OP_NOP;
    alu_ui_d     = issuing ? entry[7:0]  : 8'h00;
    alu_ena_d    = (state_d != S_IDLE);
    busy_d       = (state_d != S_IDLE);
    load_ready_d = (state_d == S_IDLE) && (count_d < DEPTH_C);

    tag0_d.valid = issuing;
    tag0_d.idx   = ptr_d;
    tag0_d.last  = ({1'b0, ptr_d} == last_idx);

    res_valid_d = tag2_q.valid;
    res_index_d = tag2_q.valid ? tag2_q.idx : res_index_q;
    res_data_d  = tag2_q.valid ? alu_result : res_data_q;
    done_d      = (tag2_q.valid & tag2_q.last) | empty_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      ptr_q        <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      alu_op_q     <= OP_NOP;
      alu_ui_q     <= 8'h00;
      alu_ena_q    <= 1'b0;
      tag0_q       <= '0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 8'h00;
      res_index_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      alu_op_q     <= alu_op_d;
      alu_ui_q     <= alu_ui_d;
      alu_ena_q    <= alu_ena_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag0_q;
      tag2_q       <= tag1_q;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_index_q  <= res_index_d;
    end
  end

  // NOTE: the program memory is deliberately not reset; count_q alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (load_fire) mem[count_q[IW-1:0]] <= load_data;
  end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign alu_op     = alu_op_q;
  assign alu_ui     = alu_ui_q;
  assign alu_ena    = alu_ena_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_index  = res_index_q;

endmodule
